pwm_multi_ramp: RTL and testbench
=================================

# pwm_multi_ramp

Parametrised multi-channel PWM generator with a shared runtime-programmable prescaler, configurable duty resolution and glitch-free duty updates at period boundaries. An optional per-channel linear ramp slews the active duty toward a written target, giving soft start and stop for DC motors and LED fades. It sits between button/counter control logic and the motor, servo and LED pins, and supersedes the fixed 100-step and 1000-step PWM blocks.

## Interface
- CH, 3 — number of PWM channels.
- RES, 1000 — steps per PWM period. Legal range 2..65535.
- PW, 24 — prescaler width.
- DW, $clog2(RES+1) — derived duty width. Not overridden by users.

- clk  in  1  system clock (125 MHz on the board).
- reset_n  in  1  asynchronous, active-low reset.
- presc  in  PW  clk cycles per PWM step, minus 1.
- ramp_div  in  16  PWM periods per ramp step, minus 1. Ignored without the ramp macro.
- duty_we  in  CH  per-channel target write strobe.
- duty_wdata  in  CH*DW  per-channel target value; channel i occupies bits [i*DW +: DW].
- pwm_out  out  CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse at each period boundary.
- duty_cur  out  CH*DW  active duty per channel.
- at_target  out  CH  high when active duty equals target.

## Operation
- **Prescaler:**
  - pcnt counts up each clk.
  - When pcnt >= presc, pcnt returns to 0 and tick pulses for that cycle.
  - presc=0 produces a tick every cycle.
  - If presc is lowered below the current pcnt, tick fires on the next cycle.
- **Step counter:**
  - step advances 0..RES-1 on each tick.
  - On the tick where step = RES-1, step wraps to 0 and period_start pulses in that same cycle.
  - This wrap cycle is the "boundary".
- **Target registers:**
  - A duty_we[i] write loads target[i] = min(wdata_i, RES). Values above RES saturate to RES.
  - Writes are accepted on any cycle.
- **Active duty update:** happens only at a boundary.
  - Ramp enabled: a ramp counter counts boundaries 0..ramp_div. At the boundary where it equals ramp_div, it clears and every channel with active ≠ target moves active by exactly 1 toward target.
  - Ramp disabled: active[i] = target[i] at every boundary.
- **Output compare:**
  - pwm_out[i] is registered as (step < active[i]), using the step and active values of the previous cycle.
  - active=0 gives a constant low output.
  - active=RES gives a constant high output.
- **Status:**
  - at_target[i] = (active[i] == target[i]), combinational from the registers.
  - duty_cur presents the active registers directly.
- **Simultaneous events:**
  - A write in the same cycle as a boundary: the boundary uses the old target, and the new target applies from the next boundary.
  - Writes to several channels in one cycle are all accepted.
  - A retarget in mid-ramp changes direction at the next ramp step, with no overshoot.
- **Reset:**
  - Asserting reset_n low at any time, including mid-period or mid-ramp, clears pcnt, step, ramp counter, targets and active duties.
  - After reset: pwm_out = 0, period_start = 0, duty_cur = 0, at_target = all 1.

## Timing
- Write to target: visible on the next clk edge; at_target updates in the same cycle.
- Target to active: applied at the next boundary (no ramp), or one unit per (ramp_div+1) periods (ramp).
- active/step to pwm_out: 1 cycle latency.
- Period length: (presc+1)*RES clk cycles.
- Example: presc=1249, RES=100 gives 1 kHz at 125 MHz.
- Duty resolution: 1/RES.
- Full ramp from 0 to RES: RES*(ramp_div+1) periods.
- First boundary after reset: after RES ticks.

## Configuration
- **PWM_RAMP_EN defined:**
  - The ramp counter and per-channel slew logic are built.
  - ramp_div is honoured.
- **PWM_RAMP_EN undefined:**
  - The ramp logic is omitted.
  - Active duty jumps to target at the next boundary.
  - ramp_div is unconnected internally.
  - All other behaviour is identical.

## Test plan
Setup for all scenarios: CH=3, RES=10, presc=1, so one period is 20 clk.

- **Reset:** assert reset_n low at step 6 with active[0]=7 -> next cycle pwm_out=000, duty_cur=0, period_start=0, at_target=111; release -> first period_start after 20 clk.
- **No ramp:** macro undefined, write ch0=5 -> at_target[0]=0 until the next boundary, then duty_cur[0]=5. pwm_out[0] is high 10 clk and low 10 clk, repeating, lagging step by 1 cycle.
- **Saturation and extremes:**
  - Write ch1=15 -> target saturates to 10, and pwm_out[1] is constant high from the first full period.
  - Write ch1=0 -> pwm_out[1] is constant low.
- **Ramp:** macro defined, ramp_div=1, write ch2=3 from 0 -> duty_cur[2] steps 1, 2, 3 at every 2nd boundary. at_target[2] rises with the step to 3.
- **Boundary collision:** write ch0=8 in the same cycle as period_start while active=5 -> that boundary leaves active at 5, or moves it toward the old target. The value 8 is applied or approached from the following boundary.
- **Prescaler change:** with pcnt=1, drop presc from 1 to 0 -> tick fires on the next cycle, and steps then advance every clk, giving 10 clk periods.

Source files
------------

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM with a shared runtime prescaler and duty updates only at period boundaries.
// Define PWM_RAMP_EN to build the per-channel linear ramp that slews active duty toward target.
module pwm_multi_ramp #(
  parameter int CH  = 3,
  parameter int RES = 1000,
  parameter int PW  = 24,
  parameter int DW  = $clog2(RES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PW-1:0]    presc,
  input  logic [15:0]      ramp_div,
  input  logic [CH-1:0]    duty_we,
  input  logic [CH*DW-1:0] duty_wdata,
  output logic [CH-1:0]    pwm_out,
  output logic             period_start,
  output logic [CH*DW-1:0] duty_cur,
  output logic [CH-1:0]    at_target
);

  localparam logic [DW-1:0] RES_V  = DW'(RES);
  localparam logic [DW-1:0] STEP_L = DW'(RES - 1);

  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [DW-1:0]          step_q, step_d;
  logic [CH-1:0][DW-1:0]  target_q, target_d;
  logic [CH-1:0][DW-1:0]  active_q, active_d;
  logic [CH-1:0]          pwm_q, pwm_d;
  logic [DW-1:0]          wdata_i;
  logic                   tick;
  logic                   boundary;

  // A lowered presc below the running count must still tick at once, hence >= rather than ==.
  always_comb begin
    tick     = (pcnt_q >= presc);
    boundary = tick && (step_q == STEP_L);
    pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
    step_d   = step_q;
    if (tick) begin
      step_d = (step_q == STEP_L) ? '0 : step_q + DW'(1);
    end
  end

  always_comb begin
    target_d = target_q;
    wdata_i  = '0;
    for (int i = 0; i < CH; i++) begin
      wdata_i = duty_wdata[i*DW +: DW];
      if (duty_we[i]) begin
        target_d[i] = (wdata_i > RES_V) ? RES_V : wdata_i;
      end
    end
  end

`ifdef PWM_RAMP_EN
  logic [15:0] rcnt_q, rcnt_d;
  logic        ramp_step;

  always_comb begin
    rcnt_d    = rcnt_q;
    ramp_step = 1'b0;
    if (boundary) begin
      if (rcnt_q == ramp_div) begin
        rcnt_d    = '0;
        ramp_step = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rcnt_q <= '0;
    else          rcnt_q <= rcnt_d;
  end

  // One unit per ramp step toward the registered target, so a retarget never overshoots.
  always_comb begin
    active_d = active_q;
    for (int i = 0; i < CH; i++) begin
      if (ramp_step) begin
        if (active_q[i] < target_q[i])      active_d[i] = active_q[i] + DW'(1);
        else if (active_q[i] > target_q[i]) active_d[i] = active_q[i] - DW'(1);
      end
    end
  end
`else
  logic unused_ramp_div;
  assign unused_ramp_div = ^ramp_div;

  always_comb begin
    active_d = active_q;
    if (boundary) begin
      active_d = target_q;
    end
  end
`endif

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = (step_q < active_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q   <= '0;
      step_q   <= '0;
      target_q <= '0;
      active_q <= '0;
      pwm_q    <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      step_q   <= step_d;
      target_q <= target_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    at_target = '0;
    for (int i = 0; i < CH; i++) begin
      at_target[i] = (active_q[i] == target_q[i]);
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = boundary;
  assign duty_cur     = active_q;

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Self-checking bench for pwm_multi_ramp: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic model (honours PWM_RAMP_EN like the design).
module tb_pwm_multi_ramp;

  localparam int CH  = 3;
  localparam int RES = 10;
  localparam int PW  = 24;
  localparam int DW  = $clog2(RES + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic [PW-1:0]    presc;
  logic [15:0]      ramp_div;
  logic [CH-1:0]    duty_we;
  logic [CH*DW-1:0] duty_wdata;
  logic [CH-1:0]    pwm_out;
  logic             period_start;
  logic [CH*DW-1:0] duty_cur;
  logic [CH-1:0]    at_target;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  pwm_multi_ramp #(.CH(CH), .RES(RES), .PW(PW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .presc        (presc),
    .ramp_div     (ramp_div),
    .duty_we      (duty_we),
    .duty_wdata   (duty_wdata),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_cur     (duty_cur),
    .at_target    (at_target)
  );

  always #5 clk = ~clk;

  // Reference state: time since last tick, position in the period, targets and active duties.
  int            m_since = 0;
  int            m_step  = 0;
  int            m_target[CH];
  int            m_active[CH];
  logic [CH-1:0] m_pwm = '0;
`ifdef PWM_RAMP_EN
  int            m_rcnt = 0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_since = 0;
    m_step  = 0;
    m_pwm   = '0;
    for (int i = 0; i < CH; i++) begin
      m_target[i] = 0;
      m_active[i] = 0;
    end
`ifdef PWM_RAMP_EN
    m_rcnt = 0;
`endif
  endtask

  task automatic modelStep();
    bit tick;
    bit bnd;
    int wv;
    tick = (m_since >= int'(presc));
    bnd  = tick && (m_step == RES - 1);
    for (int i = 0; i < CH; i++) m_pwm[i] = (m_step < m_active[i]);
    if (bnd) begin
`ifdef PWM_RAMP_EN
      if (m_rcnt == int'(ramp_div)) begin
        m_rcnt = 0;
        for (int i = 0; i < CH; i++) begin
          if (m_active[i] < m_target[i])      m_active[i] = m_active[i] + 1;
          else if (m_active[i] > m_target[i]) m_active[i] = m_active[i] - 1;
        end
      end else begin
        m_rcnt = (m_rcnt + 1) % 65536;
      end
`else
      for (int i = 0; i < CH; i++) m_active[i] = m_target[i];
`endif
    end
    if (tick) begin
      m_since = 0;
      m_step  = (m_step + 1) % RES;
    end else begin
      m_since = m_since + 1;
    end
    for (int i = 0; i < CH; i++) begin
      if (duty_we[i]) begin
        wv = int'(duty_wdata[i*DW +: DW]);
        m_target[i] = (wv > RES) ? RES : wv;
      end
    end
  endtask

  initial modelReset();

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) modelReset();
    else          modelStep();
  end

  // Outputs settle after the posedge; compare on every falling edge.
  always @(negedge clk) begin : cmp
    logic [CH-1:0]    e_at;
    logic [CH*DW-1:0] e_duty;
    logic             e_ps;
    e_at   = '0;
    e_duty = '0;
    for (int i = 0; i < CH; i++) begin
      e_duty[i*DW +: DW] = DW'(m_active[i]);
      e_at[i]            = (m_active[i] == m_target[i]);
    end
    e_ps = reset_n && (m_since >= int'(presc)) && (m_step == RES - 1);
    if (!done) begin
      checkOutput("pwm_out", 32'(pwm_out), 32'(m_pwm));
      checkOutput("period_start", 32'(period_start), 32'(e_ps));
      checkOutput("duty_cur", 32'(duty_cur), 32'(e_duty));
      checkOutput("at_target", 32'(at_target), 32'(e_at));
    end
  end

  task automatic applyStimulus(input logic [CH-1:0] we, input logic [CH*DW-1:0] wd);
    @(posedge clk);
    #1;
    duty_we    = we;
    duty_wdata = wd;
    @(posedge clk);
    #1;
    duty_we = '0;
  endtask

  task automatic waitPeriodStart(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (period_start) seen = 1'b1;
    end
    if (!seen) checkOutput("ps_timeout", 32'(0), 32'(1));
  endtask

  task automatic countHigh(input int ch, output int highs);
    highs = 0;
    for (int k = 0; k < 2 * RES; k++) begin
      @(negedge clk);
      if (pwm_out[ch]) highs++;
    end
  endtask

  initial begin
    int n;
    int highs;
    reset_n    = 1'b0;
    presc      = PW'(1);
    ramp_div   = 16'd0;
    duty_we    = '0;
    duty_wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_pwm", 32'(pwm_out), 32'h0);
    checkOutput("rst_ps", 32'(period_start), 32'h0);
    checkOutput("rst_duty", 32'(duty_cur), 32'h0);
    checkOutput("rst_at", 32'(at_target), 32'h7);

    @(posedge clk);
    #1 reset_n = 1'b1;
    waitPeriodStart(100, n);
    checkOutput("first_boundary", 32'(n), 32'd20);

    // Ch0 target 5: not at target until the next boundary moves active.
    applyStimulus(3'b001, (CH*DW)'(5));
    @(negedge clk);
    checkOutput("ch0_at_before", 32'(at_target[0]), 32'h0);
    waitPeriodStart(100, n);
    @(negedge clk);
`ifdef PWM_RAMP_EN
    checkOutput("ch0_after_bnd", 32'(duty_cur[DW-1:0]), 32'd1);
`else
    checkOutput("ch0_after_bnd", 32'(duty_cur[DW-1:0]), 32'd5);
`endif

    // Saturation and the two extremes on ch1.
    applyStimulus(3'b010, (CH*DW)'(15) << DW);
    repeat (12) waitPeriodStart(100, n);
    @(negedge clk);
    checkOutput("ch1_saturate", 32'(duty_cur[DW +: DW]), 32'd10);
    countHigh(1, highs);
    checkOutput("ch1_full_high", 32'(highs), 32'd20);
    applyStimulus(3'b010, '0);
    repeat (12) waitPeriodStart(100, n);
    @(negedge clk);
    countHigh(1, highs);
    checkOutput("ch1_full_low", 32'(highs), 32'd0);

    // Write ch0=8 in the very cycle of a boundary; that boundary must use the old target.
    waitPeriodStart(100, n);
    repeat (2 * RES) @(posedge clk);
    #1;
    duty_we    = 3'b001;
    duty_wdata = (CH*DW)'(8);
    @(negedge clk);
    checkOutput("collide_ps", 32'(period_start), 32'h1);
    @(posedge clk);
    #1 duty_we = '0;
    @(negedge clk);
    checkOutput("collide_keep", 32'(duty_cur[DW-1:0]), 32'd5);
    waitPeriodStart(100, n);
    @(negedge clk);
`ifdef PWM_RAMP_EN
    checkOutput("collide_next", 32'(duty_cur[DW-1:0]), 32'd6);
`else
    checkOutput("collide_next", 32'(duty_cur[DW-1:0]), 32'd8);
`endif

    // presc=0: one step per clk, so boundaries every RES cycles.
    @(posedge clk);
    #1 presc = PW'(0);
    waitPeriodStart(100, n);
    waitPeriodStart(100, n);
    checkOutput("presc0_period", 32'(n), 32'd10);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      duty_we = '0;
      if ($urandom_range(0, 7) == 0) begin
        duty_we    = CH'($urandom_range(1, 7));
        duty_wdata = (CH*DW)'($urandom);
      end
      if ($urandom_range(0, 149) == 0) presc = PW'($urandom_range(0, 2));
      if ($urandom_range(0, 299) == 0) ramp_div = 16'($urandom_range(0, 2));
      if (!reset_n)                         reset_n = 1'b1;
      else if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    duty_we = '0;
    repeat (5) @(negedge clk);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
